// File: rtl/seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seq_pkg
// Description : Shared types and constants for the state sequencer. Holds the
//               playback FSM encoding, the width of a recorded state and a
//               helper for the width of one program entry.
// Revision    : 1.0 - initial release
// ============================================================================
package seq_pkg;

    // Playback controller states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        DWELL = 2'd2
    } seq_state_t;

    // Width of the board state forwarded through the mux.
    localparam int STATE_W = 3;

    // Default dwell width and the matching entry width.
    localparam int DWELL_W_DEFAULT = 4;
    localparam int ENTRY_W         = STATE_W + DWELL_W_DEFAULT;

    // One program entry is {state, dwell}.
    function automatic int entry_width(input int dwell_w);
        return STATE_W + dwell_w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/tick_gen.sv
`default_nettype none
// ============================================================================
// Module      : tick_gen
// Description : Dwell prescaler. Emits a one-cycle tick every TICK_DIV clock
//               cycles, counting from the cycle after clr is released.
// Ports       : clk     - system clock
//               reset_n - synchronous active-low reset
//               clr     - synchronous restart of the prescaler
//               tick    - one-cycle pulse every TICK_DIV cycles
// Revision    : 1.0 - initial release
// ============================================================================
module tick_gen #(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clr,
    output logic tick
);

    localparam int                c_cnt_w = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(TICK_DIV - 1);

    logic [c_cnt_w-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_cnt <= '0;
        end else if (clr || (r_cnt == c_last)) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Masked during clr so a restart never coincides with a stale tick.
    assign tick = !clr && (r_cnt == c_last);

endmodule
`default_nettype wire

// File: rtl/state_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : state_sequencer
// Description : Record/playback controller for the board state-select mux.
//               In record mode (mode_play=0) each rising edge of record_btn
//               stores {manual_state, dwell_in} into the next program slot.
//               In playback mode the program is stepped through cyclically;
//               each entry is held on CurrentState_mem for dwell ticks and
//               sel_mem is raised while a valid entry is being presented.
// Ports       : clk, reset_n        - clock, synchronous active-low reset
//               mode_play           - 1 = playback, 0 = record/manual
//               record_btn          - debounced record button (level)
//               clear               - synchronous program erase
//               manual_state        - state value to record
//               dwell_in            - dwell ticks to record
//               CurrentState_mem    - registered playback state
//               sel_mem             - mux select, high during DWELL
//               step_index          - entry currently played
//               count               - number of recorded entries
//               full                - count == DEPTH
// Revision    : 1.0 - initial release
// ============================================================================
module state_sequencer
    import seq_pkg::*;
#(
    parameter int DEPTH    = 8,
    parameter int DWELL_W  = 4,
    parameter int TICK_DIV = 50_000_000
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       mode_play,
    input  logic                       record_btn,
    input  logic                       clear,
    input  logic [STATE_W-1:0]         manual_state,
    input  logic [DWELL_W-1:0]         dwell_in,
    output logic [STATE_W-1:0]         CurrentState_mem,
    output logic                       sel_mem,
    output logic [$clog2(DEPTH)-1:0]   step_index,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full
);

    localparam int                 c_aw       = $clog2(DEPTH);
    localparam int                 c_ew       = entry_width(DWELL_W);
    localparam logic [c_aw:0]      c_full_cnt = (c_aw + 1)'(DEPTH);
    localparam logic [DWELL_W-1:0] c_dwell_1  = DWELL_W'(1);

    // ------------------------------------------------------------------------
    // Storage and state
    // ------------------------------------------------------------------------
    seq_state_t          r_state;
    seq_state_t          w_next_state;

    logic [c_ew-1:0]     r_mem [DEPTH];
    logic                r_btn_q;
    logic [c_aw:0]       r_count;
    logic [c_aw-1:0]     r_step;
    logic [STATE_W-1:0]  r_cur_state;
    logic [DWELL_W-1:0]  r_dwell_cnt;

    // ------------------------------------------------------------------------
    // Control strobes from the FSM
    // ------------------------------------------------------------------------
    logic                w_btn_rise;
    logic                w_full;
    logic                w_last_entry;
    logic                w_tick;
    logic                w_presc_clr;
    logic                w_do_record;
    logic                w_do_load;
    logic                w_do_advance;
    logic                w_dwell_dec;
    logic                w_step_clr;
    logic [c_ew-1:0]     w_rd_entry;
    logic [DWELL_W-1:0]  w_rd_dwell;

    assign w_btn_rise   = record_btn && !r_btn_q;
    assign w_full       = (r_count == c_full_cnt);
    assign w_last_entry = ({1'b0, r_step} == (r_count - 1'b1));
    assign w_rd_entry   = r_mem[r_step];
    assign w_rd_dwell   = w_rd_entry[DWELL_W-1:0];

    // ------------------------------------------------------------------------
    // Dwell prescaler; held in restart everywhere except DWELL so that every
    // entry gets a full dwell period measured from its first DWELL cycle.
    // ------------------------------------------------------------------------
    tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (w_presc_clr),
        .tick    (w_tick)
    );

    // ------------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------------
    // FSM next state and strobes. clear outranks a playback exit, which in
    // turn outranks recording.
    // ------------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        w_presc_clr  = 1'b1;
        w_do_record  = 1'b0;
        w_do_load    = 1'b0;
        w_do_advance = 1'b0;
        w_dwell_dec  = 1'b0;
        w_step_clr   = 1'b0;

        if (clear) begin
            w_next_state = IDLE;
            w_step_clr   = 1'b1;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_btn_rise && !w_full) begin
                        w_do_record = 1'b1;
                    end
                    if (mode_play && (r_count != '0)) begin
                        w_next_state = LOAD;
                    end
                end
                LOAD: begin
                    if (!mode_play) begin
                        w_next_state = IDLE;
                        w_step_clr   = 1'b1;
                    end else begin
                        w_do_load    = 1'b1;
                        w_next_state = DWELL;
                    end
                end
                DWELL: begin
                    w_presc_clr = 1'b0;
                    if (!mode_play) begin
                        w_next_state = IDLE;
                        w_step_clr   = 1'b1;
                    end else if (w_tick) begin
                        if (r_dwell_cnt == c_dwell_1) begin
                            w_do_advance = 1'b1;
                            w_next_state = LOAD;
                        end else begin
                            w_dwell_dec = 1'b1;
                        end
                    end
                end
                default: begin
                    w_next_state = IDLE;
                    w_step_clr   = 1'b1;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Program memory: write-only from the record path, read via r_step.
    // Not reset; count alone defines which entries are valid.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_do_record) begin
            r_mem[r_count[c_aw-1:0]] <= {manual_state, dwell_in};
        end
    end

    // ------------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_btn_q     <= 1'b0;
            r_count     <= '0;
            r_step      <= '0;
            r_cur_state <= '0;
            r_dwell_cnt <= '0;
        end else begin
            // The edge detector runs in every state, so a press made during
            // playback is consumed there and never replayed later.
            r_btn_q <= record_btn;

            if (clear) begin
                r_count <= '0;
            end else if (w_do_record) begin
                r_count <= r_count + 1'b1;
            end

            if (w_step_clr) begin
                r_step <= '0;
            end else if (w_do_advance) begin
                r_step <= w_last_entry ? '0 : r_step + 1'b1;
            end

            if (w_do_load) begin
                r_cur_state <= w_rd_entry[c_ew-1 -: STATE_W];
                // A zero dwell would never expire; treat it as one tick.
                r_dwell_cnt <= (w_rd_dwell == '0) ? c_dwell_1 : w_rd_dwell;
            end else if (w_dwell_dec) begin
                r_dwell_cnt <= r_dwell_cnt - 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign CurrentState_mem = r_cur_state;
    assign sel_mem          = (r_state == DWELL);
    assign step_index       = r_step;
    assign count            = r_count;
    assign full             = w_full;

endmodule
`default_nettype wire

// File: tb/tb_state_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_state_sequencer
// Description : Scoreboard bench for state_sequencer with DEPTH=4,
//               TICK_DIV=4. Stimulus pushes the expected playback segments
//               {state, DWELL length, preceding select-low gap}; a monitor
//               reassembles segments from sel_mem/CurrentState_mem and pops
//               the scoreboard as each segment ends.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_state_sequencer;

    localparam int DEPTH    = 4;
    localparam int DWELL_W  = 4;
    localparam int TICK_DIV = 4;

    logic               clk = 1'b0;
    logic               reset_n;
    logic               mode_play;
    logic               record_btn;
    logic               clear;
    logic [2:0]         manual_state;
    logic [DWELL_W-1:0] dwell_in;
    logic [2:0]         cur_state;
    logic               sel_mem;
    logic [1:0]         step_index;
    logic [2:0]         count;
    logic               full;

    state_sequencer #(
        .DEPTH    (DEPTH),
        .DWELL_W  (DWELL_W),
        .TICK_DIV (TICK_DIV)
    ) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .mode_play        (mode_play),
        .record_btn       (record_btn),
        .clear            (clear),
        .manual_state     (manual_state),
        .dwell_in         (dwell_in),
        .CurrentState_mem (cur_state),
        .sel_mem          (sel_mem),
        .step_index       (step_index),
        .count            (count),
        .full             (full)
    );

    always #5 clk = ~clk;

    typedef struct {
        int st;
        int len;
        int gap;   // -1: gap not checked
    } seg_t;

    seg_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_seg(input int st, input int len, input int gap);
        seg_t s;
        s.st  = st;
        s.len = len;
        s.gap = gap;
        exp_q.push_back(s);
    endtask

    task automatic do_clear();
        clear = 1'b1;
        cyc(1);
        clear = 1'b0;
        cyc(1);
    endtask

    task automatic record(input int st, input int dw, input int exp_cnt, input int exp_full);
        manual_state = 3'(st);
        dwell_in     = DWELL_W'(dw);
        record_btn   = 1'b1;
        cyc(1);
        check("rec_count", int'(count), exp_cnt);
        check("rec_full", int'(full), exp_full);
        record_btn = 1'b0;
        cyc(1);
    endtask

    // ------------------------------------------------------------------------
    // Monitor: a segment is a run of sel_mem=1; it is scored when sel drops.
    // ------------------------------------------------------------------------
    int in_seg  = 0;
    int seg_st  = 0;
    int seg_len = 0;
    int seg_gap = 0;
    int gap_cnt = 1000;

    always @(negedge clk) begin
        if (sel_mem === 1'b1) begin
            if (in_seg == 0) begin
                in_seg  = 1;
                seg_st  = int'(cur_state);
                seg_len = 1;
                seg_gap = gap_cnt;
            end else begin
                seg_len++;
                if (int'(cur_state) != seg_st) seg_st = -1;
            end
        end else begin
            if (in_seg != 0) begin
                in_seg  = 0;
                gap_cnt = 1;
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL seg_unexpected: got state %0d len %0d, expected no segment",
                             seg_st, seg_len);
                end else begin
                    seg_t e;
                    e = exp_q.pop_front();
                    if (seg_st != e.st || seg_len != e.len ||
                        (e.gap >= 0 && seg_gap != e.gap)) begin
                        n_fail++;
                        $display("FAIL seg: got state %0d len %0d gap %0d, expected state %0d len %0d gap %0d",
                                 seg_st, seg_len, seg_gap, e.st, e.len, e.gap);
                    end
                end
            end else begin
                gap_cnt++;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------------
    initial begin
        reset_n      = 1'b0;
        mode_play    = 1'b0;
        record_btn   = 1'b0;
        clear        = 1'b0;
        manual_state = '0;
        dwell_in     = '0;
        cyc(2);
        check("rst_state", int'(cur_state), 0);
        check("rst_sel", int'(sel_mem), 0);
        check("rst_step", int'(step_index), 0);
        check("rst_count", int'(count), 0);
        check("rst_full", int'(full), 0);
        reset_n = 1'b1;
        cyc(1);

        // Three entries, cyclic playback with wrap back to entry 0.
        record(3, 2, 1, 0);
        record(5, 1, 2, 0);
        record(6, 3, 3, 0);
        push_seg(3, 8, -1);
        push_seg(5, 4, 1);
        push_seg(6, 12, 1);
        push_seg(3, 8, 1);
        mode_play = 1'b1;
        cyc(11);
        check("p1_step", int'(step_index), 1);
        check("p1_state", int'(cur_state), 5);
        cyc(26);
        mode_play = 1'b0;            // lands in LOAD of entry 1
        cyc(1);
        check("p1_exit_sel", int'(sel_mem), 0);
        check("p1_exit_step", int'(step_index), 0);
        check("p1_exit_hold", int'(cur_state), 3);
        cyc(2);

        // Fill to DEPTH, fifth press ignored.
        do_clear();
        check("clr_count", int'(count), 0);
        record(1, 1, 1, 0);
        record(2, 1, 2, 0);
        record(3, 1, 3, 0);
        record(4, 1, 4, 1);
        record(7, 5, 4, 1);
        push_seg(1, 4, -1);
        push_seg(2, 4, 1);
        push_seg(3, 4, 1);
        push_seg(4, 4, 1);
        mode_play = 1'b1;
        cyc(21);
        mode_play = 1'b0;
        cyc(2);

        // Held button records once; dwell 0 plays as dwell 1.
        do_clear();
        manual_state = 3'd5;
        dwell_in     = '0;
        record_btn   = 1'b1;
        cyc(20);
        check("hold_count", int'(count), 1);
        record_btn = 1'b0;
        cyc(1);
        check("hold_count2", int'(count), 1);
        push_seg(5, 4, -1);
        push_seg(5, 4, 1);
        mode_play = 1'b1;
        cyc(11);
        mode_play = 1'b0;
        cyc(2);

        // Playback request with an empty program.
        do_clear();
        mode_play = 1'b1;
        cyc(20);
        check("empty_sel", int'(sel_mem), 0);
        check("empty_step", int'(step_index), 0);
        check("empty_count", int'(count), 0);
        mode_play = 1'b0;
        cyc(1);

        // Exit mid-DWELL of entry 1, restart from entry 0, then clear.
        record(2, 1, 1, 0);
        record(7, 2, 2, 0);
        push_seg(2, 4, -1);
        push_seg(7, 3, 1);
        mode_play = 1'b1;
        cyc(9);
        mode_play = 1'b0;
        cyc(1);
        check("drop_sel", int'(sel_mem), 0);
        check("drop_step", int'(step_index), 0);
        check("drop_hold", int'(cur_state), 7);
        push_seg(2, 4, -1);
        push_seg(7, 8, 1);
        push_seg(2, 2, 1);
        mode_play = 1'b1;
        cyc(17);
        clear = 1'b1;
        cyc(1);
        check("clr_dw_count", int'(count), 0);
        check("clr_dw_sel", int'(sel_mem), 0);
        check("clr_dw_full", int'(full), 0);
        check("clr_dw_step", int'(step_index), 0);
        clear     = 1'b0;
        mode_play = 1'b0;
        cyc(2);

        // Reset during DWELL.
        record(4, 1, 1, 0);
        push_seg(4, 2, -1);
        mode_play = 1'b1;
        cyc(3);
        reset_n = 1'b0;
        cyc(1);
        check("rdw_state", int'(cur_state), 0);
        check("rdw_sel", int'(sel_mem), 0);
        check("rdw_step", int'(step_index), 0);
        check("rdw_count", int'(count), 0);
        check("rdw_full", int'(full), 0);
        reset_n   = 1'b1;
        mode_play = 1'b0;
        cyc(3);

        check("scoreboard_left", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/state_sequencer.md
# state_sequencer

Record/playback controller that drives the memory-side input of the board's state-select mux and generates its select line. In record mode the block captures operator-set 3-bit states, each with a dwell time, into a small on-chip program. In playback mode it steps through the program cyclically and asserts `sel_mem` so that the mux forwards `CurrentState_mem` instead of the manual switch state.

## Interface
Parameters:
- `DEPTH`, 8: program entries. Power of two, at least 2.
- `DWELL_W`, 4: width of the per-entry dwell count, in ticks.
- `TICK_DIV`, 50_000_000: clock cycles per dwell tick (1 s at 50 MHz).

Ports:
- `clk`  in  1  system clock. The block uses this one clock only.
- `reset_n`  in  1  synchronous, active-low reset.
- `mode_play`  in  1  level input. 1 selects playback; 0 selects record/manual.
- `record_btn`  in  1  level input, active-high. Already debounced.
- `clear`  in  1  synchronous program erase.
- `manual_state`  in  3  state value to record.
- `dwell_in`  in  DWELL_W  dwell value to record.
- `CurrentState_mem`  out  3  current playback state, registered.
- `sel_mem`  out  1  mux select. 1 while a valid playback entry is on `CurrentState_mem`.
- `step_index`  out  log2(DEPTH)  index of the entry being played.
- `count`  out  log2(DEPTH)+1  number of recorded entries.
- `full`  out  1  high when `count == DEPTH`.

## Operation
- Reset values: `CurrentState_mem`=0, `sel_mem`=0, `step_index`=0, `count`=0, `full`=0, FSM in IDLE, prescaler at 0. Memory contents are not reset.
- FSM states: IDLE, LOAD, DWELL.
- IDLE → LOAD when `mode_play`=1 and `count`>0. If `mode_play`=1 and `count`=0, the FSM stays in IDLE with `sel_mem`=0.
- LOAD: presents the read address `step_index`, clears the prescaler, then goes to DWELL.
- DWELL: registers the read state to `CurrentState_mem` and the dwell value to the dwell counter. A dwell value of 0 is loaded as 1. The counter decrements on each tick. When a tick arrives with the counter at 1:
  - `step_index` increments, wrapping to 0 after `count-1`.
  - The FSM returns to LOAD.
- `mode_play`=0 in LOAD or DWELL: next state is IDLE, `sel_mem`=0, `step_index`=0. `CurrentState_mem` holds its last value.
- Recording happens in IDLE only. The rising edge of `record_btn` (internal edge detect) writes {`manual_state`, `dwell_in`} to entry `count`, and `count` increments.
  - A button held high records exactly once.
  - When `full` is high, further presses are ignored.
  - A `record_btn` edge while in LOAD or DWELL is discarded. It is not deferred.
- `clear`, in any state: `count`=0, `full`=0, `step_index`=0, FSM to IDLE, `sel_mem`=0.
- Priority: `reset_n` > `clear` > `mode_play` exit > record. A record edge in the same cycle as `clear` is dropped.

## Timing
- Cycle N: IDLE samples `mode_play`=1 with `count`>0. Cycle N+1: LOAD. Cycle N+2: DWELL, `sel_mem`=1, entry 0 on `CurrentState_mem`.
- Each entry occupies dwell×TICK_DIV cycles in DWELL, plus 1 LOAD cycle. `sel_mem` drops for that LOAD cycle only. The mux must tolerate this: during LOAD it passes the manual state for 1 cycle.
- Memory read is synchronous with 1-cycle latency and is inferable as block RAM.
- Record write: `count` updates 1 cycle after the rising edge of `record_btn` is sampled. `full` updates in the same cycle as `count`.
- A `mode_play` drop is seen at the next edge: `sel_mem`=0 one cycle later.
- `reset_n` low mid-playback: all outputs take their reset values at the next edge. Recorded contents are lost logically because `count`=0.

## Structure
- Package `seq_pkg` holds:
  - the FSM state enum {IDLE, LOAD, DWELL};
  - `STATE_W`=3;
  - the entry width `STATE_W+DWELL_W`.
- One sub-module, `tick_gen`:
  - parameter `TICK_DIV`;
  - inputs `clk`, `reset_n`, `clr`;
  - output `tick`, a 1-cycle pulse every `TICK_DIV` cycles after `clr`.
- Edge detect, write pointer, memory array and FSM stay in `state_sequencer`.

## Test plan
All scenarios use TICK_DIV=4, DEPTH=4.
- Record {3,dwell 2}, {5,dwell 1}, {6,dwell 3}, then set `mode_play`=1. `CurrentState_mem` must show 3 for 8 DWELL cycles, then 5 for 4, then 6 for 12, then 3 again. `sel_mem` must be low exactly during each LOAD cycle.
- Make 5 record presses. Required: `count`=4 and `full`=1 after the 4th; the 5th leaves entry 3 unchanged.
- Hold `record_btn` high for 20 cycles. Required: `count` increments by exactly 1.
- Record dwell 0 and play. Required: the entry lasts 4 DWELL cycles, the same as dwell 1.
- Set `mode_play`=1 with `count`=0. Required: `sel_mem` stays 0 and the FSM stays in IDLE.
- Play two entries. Drop `mode_play` mid-DWELL of entry 1, then raise it again. Required: `sel_mem`=0 the next cycle; replay restarts at entry 0. Assert `clear` during DWELL: required `count`=0 and `sel_mem`=0 the next cycle. Assert `reset_n`=0 during DWELL: required all outputs at reset values.
